// File: rtl/counter_down_mod_t_pkg.sv
// Shared types and helpers for the modulo-N T-flip-flop down counter.
package counter_down_mod_t_pkg;

  // Per-edge operation selected by the control inputs (load beats en).
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_DEC  = 2'd1,
    OP_LOAD = 2'd2
  } op_e;

  function automatic op_e decode_op(input logic load, input logic en);
    if (load) return OP_LOAD;
    if (en)   return OP_DEC;
    return OP_HOLD;
  endfunction

  // MODULUS must be 2..2^WIDTH for every state to be representable.
  function automatic bit modulus_ok(input int width, input int modulus);
    return (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/counter_down_mod_t_if.sv
// Control/data bundle of the down counter: enable, load, load value and
// the count, zero and terminal-count outputs.
interface counter_down_mod_t_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             zero;
  logic             tc;

  modport master (output en, load, d, input q, zero, tc);
  modport slave  (input en, load, d, output q, zero, tc);
endinterface

// File: rtl/counter_down_mod_t_tff.sv
// T flip-flop with active-low asynchronous clear and preset (clear wins).
module tff (
  output logic q,
  output logic qnot,
  input  logic t,
  input  logic clk,
  input  logic preset,
  input  logic clear
);

  // Toggle on rising clk when t is set; async clear/preset override.
  always_ff @(posedge clk or negedge clear or negedge preset) begin
    if (!clear)       q <= 1'b0;
    else if (!preset) q <= 1'b1;
    else if (t)       q <= ~q;
  end

  assign qnot = ~q;

endmodule

// File: rtl/counter_down_mod_t.sv
// Modulo-MODULUS down counter built from T flip-flops: counts MODULUS-1
// down to 0 and wraps, with enable, clamped synchronous load and a cascade
// terminal-count output.
module counter_down_mod_t
  import counter_down_mod_t_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 6
) (
  input logic                clk,
  input logic                clear,
  counter_down_mod_t_if.slave bus
);

  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $fatal(1, "counter_down_mod_t: MODULUS %0d outside 2..2^%0d", MODULUS, WIDTH);
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] q_bits;
  logic [WIDTH-1:0] qn_bits;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] t_bits;

  // Next count: load (clamped to MAX_VAL when out of range) > decrement with wrap > hold.
  always_comb begin
    nxt = q_bits;
    unique case (decode_op(bus.load, bus.en))
      OP_LOAD: nxt = ({1'b0, bus.d} < MOD_EXT) ? bus.d : MAX_VAL;
      OP_DEC:  nxt = (q_bits == '0) ? MAX_VAL : q_bits - ONE;
      default: nxt = q_bits;
    endcase
  end

  // Each bit toggles exactly where the next state differs from the current one.
  assign t_bits = q_bits ^ nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff u_tff (
      .q      (q_bits[i]),
      .qnot   (qn_bits[i]),
      .t      (t_bits[i]),
      .clk    (clk),
      .preset (1'b1),
      .clear  (clear)
    );
  end

  assign bus.q    = q_bits;
  assign bus.zero = &qn_bits;
  assign bus.tc   = clear & bus.en & bus.zero;

endmodule

// File: tb/tb_counter_down_mod_t.sv
// Scoreboard bench for counter_down_mod_t (WIDTH=3, MODULUS=6) plus a
// two-stage cascade giving a 36-state combined countdown.
module tb_counter_down_mod_t;

  logic clk;
  logic clear;
  logic c_clear;

  counter_down_mod_t_if #(.WIDTH(3)) bus ();
  counter_down_mod_t_if #(.WIDTH(3)) lo_bus ();
  counter_down_mod_t_if #(.WIDTH(3)) hi_bus ();

  counter_down_mod_t #(.WIDTH(3), .MODULUS(6)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  counter_down_mod_t #(.WIDTH(3), .MODULUS(6)) u_lo (
    .clk   (clk),
    .clear (c_clear),
    .bus   (lo_bus.slave)
  );

  counter_down_mod_t #(.WIDTH(3), .MODULUS(6)) u_hi (
    .clk   (clk),
    .clear (c_clear),
    .bus   (hi_bus.slave)
  );

  assign hi_bus.en = lo_bus.tc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    bit         chk_m;
    logic [2:0] q;
    logic       zero;
    logic       tc;
    bit         chk_c;
    logic [2:0] hq;
    logic [2:0] lq;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  event async_ev;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_entry(input exp_t e);
    if (e.chk_m) begin
      cmp({e.name, "_q"},    8'(bus.q),    8'(e.q));
      cmp({e.name, "_zero"}, 8'(bus.zero), 8'(e.zero));
      cmp({e.name, "_tc"},   8'(bus.tc),   8'(e.tc));
    end
    if (e.chk_c) begin
      cmp({e.name, "_hi"}, 8'(hi_bus.q), 8'(e.hq));
      cmp({e.name, "_lo"}, 8'(lo_bus.q), 8'(e.lq));
    end
  endtask

  // Post-edge monitor: one expected entry per clock edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) check_entry(sb.pop_front());
    end
  end

  // Asynchronous monitor: checks taken between edges (clear assertion).
  initial begin
    forever begin
      @(async_ev);
      if (sb.size() > 0) check_entry(sb.pop_front());
    end
  end

  function automatic void push_m(input string n, input logic [2:0] eq, input logic en_v);
    exp_t e;
    e.name  = n;
    e.chk_m = 1'b1;
    e.q     = eq;
    e.zero  = (eq == 3'd0);
    e.tc    = en_v && (eq == 3'd0);
    e.chk_c = 1'b0;
    e.hq    = '0;
    e.lq    = '0;
    sb.push_back(e);
  endfunction

  task automatic step(input string n, input logic ld, input logic en_v,
                      input logic [2:0] dv, input logic [2:0] eq);
    @(negedge clk);
    bus.load = ld;
    bus.en   = en_v;
    bus.d    = dv;
    push_m(n, eq, en_v);
  endtask

  initial begin
    exp_t e;
    int   v;
    clear       = 1'b0;
    c_clear     = 1'b0;
    bus.en      = 1'b1;
    bus.load    = 1'b0;
    bus.d       = '0;
    lo_bus.en   = 1'b1;
    lo_bus.load = 1'b0;
    lo_bus.d    = '0;
    hi_bus.load = 1'b0;
    hi_bus.d    = '0;

    // Reset state: q=0, zero=1, tc gated low by clear even with en=1.
    #3;
    e = '{name: "reset", chk_m: 1'b1, q: 3'd0, zero: 1'b1, tc: 1'b0,
          chk_c: 1'b1, hq: 3'd0, lq: 3'd0};
    sb.push_back(e);
    ->async_ev;

    // Release: first active edge goes 0 -> 5.
    @(negedge clk);
    clear = 1'b1;
    push_m("rel", 3'd5, 1'b1);

    step("dec4", 1'b0, 1'b1, 3'd0, 3'd4);
    step("dec3", 1'b0, 1'b1, 3'd0, 3'd3);
    step("dec2", 1'b0, 1'b1, 3'd0, 3'd2);
    step("dec1", 1'b0, 1'b1, 3'd0, 3'd1);
    step("dec0", 1'b0, 1'b1, 3'd0, 3'd0);
    step("wrap5", 1'b0, 1'b1, 3'd0, 3'd5);
    step("dec4b", 1'b0, 1'b1, 3'd0, 3'd4);

    // Load in range, then keep counting.
    step("ld3", 1'b1, 1'b1, 3'd3, 3'd3);
    step("ld_d2", 1'b0, 1'b1, 3'd0, 3'd2);
    step("ld_d1", 1'b0, 1'b1, 3'd0, 3'd1);
    step("ld_d0", 1'b0, 1'b1, 3'd0, 3'd0);
    step("ld_w5", 1'b0, 1'b1, 3'd0, 3'd5);

    // Clamp: out-of-range d loads MODULUS-1; d = MODULUS-1 loads as is.
    step("pre_c", 1'b0, 1'b1, 3'd0, 3'd4);
    step("ld7", 1'b1, 1'b0, 3'd7, 3'd5);
    step("pre_c2", 1'b0, 1'b1, 3'd0, 3'd4);
    step("ld6", 1'b1, 1'b0, 3'd6, 3'd5);
    step("pre_c3", 1'b0, 1'b1, 3'd0, 3'd4);
    step("ld5", 1'b1, 1'b0, 3'd5, 3'd5);

    // Hold for three edges.
    step("hold1", 1'b0, 1'b0, 3'd0, 3'd5);
    step("hold2", 1'b0, 1'b0, 3'd1, 3'd5);
    step("hold3", 1'b0, 1'b0, 3'd2, 3'd5);

    // load beats en.
    step("pre_p", 1'b0, 1'b1, 3'd0, 3'd4);
    step("prio2", 1'b1, 1'b1, 3'd2, 3'd2);
    step("ld0", 1'b1, 1'b1, 3'd0, 3'd0);
    step("w5", 1'b0, 1'b1, 3'd0, 3'd5);
    step("prio3", 1'b1, 1'b1, 3'd3, 3'd3);

    // Async clear mid-count at q=3.
    @(negedge clk);
    bus.load = 1'b0;
    bus.en   = 1'b1;
    #2;
    clear = 1'b0;
    #1;
    push_m("aclr", 3'd0, 1'b0);
    ->async_ev;
    @(negedge clk);
    clear = 1'b1;
    push_m("aclr_rel", 3'd5, 1'b1);

    // Cascade: main counter holds at 5 while the pair counts down mod 36.
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.en  = 1'b0;
      c_clear = 1'b1;
      v = (36 - (k % 36)) % 36;
      e = '{name: $sformatf("casc%0d", k), chk_m: 1'b1, q: 3'd5, zero: 1'b0,
            tc: 1'b0, chk_c: 1'b1, hq: 3'(v / 6), lq: 3'(v % 6)};
      sb.push_back(e);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
